// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM among NREQ requesters.
// Optional macro ARB_PERF_CNT_EN adds grant_cnt, a 16-bit completed-transaction counter per requester.
module rr_mem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    rden,
    input  logic [NREQ-1:0]    wren,
    input  logic [NREQ*AW-1:0] Address,
    input  logic [NREQ*DW-1:0] Din,
    input  logic [DW-1:0]      RAMq,
    output logic [NREQ-1:0]    acq,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ*DW-1:0] Dq,
    output logic [AW-1:0]      RAMAddress,
    output logic [DW-1:0]      RAMDin,
`ifdef ARB_PERF_CNT_EN
    output logic [NREQ*16-1:0] grant_cnt,
`endif
    output logic               RAMwren
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

    state_t                    state_reg, state_next;
    logic [PW-1:0]             ptr_reg, ptr_next;
    logic [PW-1:0]             gnt_reg, gnt_next;
    logic                      wr_reg, wr_next;
    logic [NREQ-1:0]           acq_reg, acq_next;
    logic [NREQ-1:0]           ack_reg, ack_next;
    logic [AW-1:0]             addr_reg, addr_next;
    logic [DW-1:0]             din_reg, din_next;
    logic                      wren_reg, wren_next;
    logic                      dq_load;
    logic [NREQ-1:0]           req;
    logic [PW-1:0]             pick;
    logic [NREQ-1:0][AW-1:0]   addr_arr;
    logic [NREQ-1:0][DW-1:0]   din_arr;
    logic [NREQ-1:0][DW-1:0]   dq_reg;

    // (base + k) mod NREQ for base < NREQ and k < NREQ
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[PW-1:0];
    endfunction

    assign addr_arr = Address;
    assign din_arr  = Din;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            // A requester being acked this cycle must not be granted again on its stale request.
            assign req[gi] = (rden[gi] | wren[gi]) & ~ack_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    dq_reg[gi] <= '0;
                end else if (dq_load && gnt_reg == PW'(gi)) begin
                    dq_reg[gi] <= RAMq;
                end
            end
            assign Dq[gi*DW +: DW] = dq_reg[gi];
        end
    endgenerate

    // Scan from ptr downwards-last so the first set bit at or after ptr wins.
    always_comb begin
        pick = ptr_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr_reg, k)]) pick = wrap_add(ptr_reg, k);
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        wr_next    = wr_reg;
        acq_next   = acq_reg;
        ack_next   = '0;
        addr_next  = addr_reg;
        din_next   = din_reg;
        wren_next  = 1'b0;
        dq_load    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    acq_next       = '0;
                    acq_next[pick] = 1'b1;
                    gnt_next       = pick;
                    wr_next        = wren[pick];
                    addr_next      = addr_arr[pick];
                    din_next       = din_arr[pick];
                    wren_next      = wren[pick];
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_reg) begin
                    ack_next[gnt_reg] = 1'b1;
                    acq_next          = '0;
                    ptr_next          = wrap_add(gnt_reg, 1);
                    state_next        = IDLE;
                end else begin
                    state_next = READ;
                end
            end
            READ: begin
                dq_load           = 1'b1;
                ack_next[gnt_reg] = 1'b1;
                acq_next          = '0;
                ptr_next          = wrap_add(gnt_reg, 1);
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            wr_reg    <= 1'b0;
            acq_reg   <= '0;
            ack_reg   <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
            wren_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            wr_reg    <= wr_next;
            acq_reg   <= acq_next;
            ack_reg   <= ack_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
            wren_reg  <= wren_next;
        end
    end

    assign acq        = acq_reg;
    assign ack        = ack_reg;
    assign RAMAddress = addr_reg;
    assign RAMDin     = din_reg;
    assign RAMwren    = wren_reg;

`ifdef ARB_PERF_CNT_EN
    logic [NREQ-1:0][15:0] cnt_reg;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (ack_next[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate
    assign grant_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Bench for rr_mem_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (grant choice, latency countdown, memory contents).
module tb_rr_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    rden = '0;
    logic [N-1:0]    wren = '0;
    logic [N*AW-1:0] Address = '0;
    logic [N*DW-1:0] Din = '0;
    logic [DW-1:0]   RAMq;
    logic [N-1:0]    acq;
    logic [N-1:0]    ack;
    logic [N*DW-1:0] Dq;
    logic [AW-1:0]   RAMAddress;
    logic [DW-1:0]   RAMDin;
    logic            RAMwren;
`ifdef ARB_PERF_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    rr_mem_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren),
        .Address(Address), .Din(Din), .RAMq(RAMq),
        .acq(acq), .ack(ack), .Dq(Dq),
        .RAMAddress(RAMAddress), .RAMDin(RAMDin),
`ifdef ARB_PERF_CNT_EN
        .grant_cnt(grant_cnt),
`endif
        .RAMwren(RAMwren)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 8'hA7 : 8'(a * 7 + 3);
    endfunction

    // Single-port RAM macro: registered read, unwritten words hold a fixed pattern.
    logic [DW-1:0] ram [256];
    bit            ram_vld [256];
    always @(posedge clk) begin
        if (RAMwren) begin
            ram[RAMAddress]     <= RAMDin;
            ram_vld[RAMAddress] <= 1'b1;
        end
        RAMq <= ram_vld[RAMAddress] ? ram[RAMAddress] : init_val(int'(RAMAddress));
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [256];
    bit            m_busy = 0;
    int            m_left = 0;
    int            m_rr   = 0;
    int            m_idx  = 0;
    bit            m_wr   = 0;
    logic [AW-1:0] m_caddr = '0;
    logic [DW-1:0] m_cdin  = '0;
    logic [N-1:0]  m_acq  = '0;
    logic [N-1:0]  m_ack  = '0;
    logic          m_wren = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din  = '0;
    logic [DW-1:0] m_dq  [N];
    int unsigned   m_cnt [N];
    int            ntxn = 0;
    bit            act [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] prev_ack;
        logic [N-1:0] pend;
        int pick;
        bit found;
        if (rst) begin
            if (m_wren) m_mem[m_addr] = m_din;
            m_busy = 0; m_rr = 0; m_acq = '0; m_ack = '0;
            m_wren = 1'b0; m_addr = '0; m_din = '0;
            for (int i = 0; i < N; i++) begin
                m_dq[i]  = '0;
                m_cnt[i] = 0;
            end
            return;
        end
        prev_ack = m_ack;
        m_ack    = '0;
        m_wren   = 1'b0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                if (m_wr) m_mem[m_caddr] = m_cdin;
                else      m_dq[m_idx] = m_mem[m_caddr];
                m_ack[m_idx] = 1'b1;
                m_acq        = '0;
                m_rr         = (m_idx + 1) % N;
                m_busy       = 0;
                m_cnt[m_idx] = (m_cnt[m_idx] + 1) & 32'hFFFF;
                ntxn++;
                $display("txn %0d: req=%0d %s addr=0x%02h data=0x%02h", ntxn, m_idx,
                         m_wr ? "write" : "read ", m_caddr, m_wr ? m_cdin : m_dq[m_idx]);
            end
        end else begin
            pend  = (rden | wren) & ~prev_ack;
            found = 0;
            pick  = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (!found && pend[j]) begin
                    found = 1;
                    pick  = j;
                end
            end
            if (found) begin
                m_busy      = 1;
                m_idx       = pick;
                m_wr        = wren[pick];
                m_caddr     = Address[pick*AW +: AW];
                m_cdin      = Din[pick*DW +: DW];
                m_left      = m_wr ? 1 : 2;
                m_acq       = '0;
                m_acq[pick] = 1'b1;
                m_addr      = m_caddr;
                m_din       = m_cdin;
                m_wren      = m_wr;
            end
        end
    endtask

    task automatic check_all();
        chk("acq", 64'(acq), 64'(m_acq));
        chk("ack", 64'(ack), 64'(m_ack));
        chk("ram_wren", 64'(RAMwren), 64'(m_wren));
        chk("ram_addr", 64'(RAMAddress), 64'(m_addr));
        chk("ram_din", 64'(RAMDin), 64'(m_din));
        for (int i = 0; i < N; i++) begin
            chk("dq", 64'(Dq[i*DW +: DW]), 64'(m_dq[i]));
`ifdef ARB_PERF_CNT_EN
            chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        rden[i] = rd;
        wren[i] = wr;
        Address[i*AW +: AW] = a;
        Din[i*DW +: DW]     = d;
    endtask

    task automatic wait_ack(input int i, input int budget, output int n);
        n = 0;
        while (!m_ack[i] && n < budget) begin
            cycle();
            n++;
        end
        chk("ack_seen", 64'(ack[i]), 64'd1);
    endtask

    task automatic start_req(input int i);
        int kind;
        kind = $urandom_range(0, 2);
        set_req(i, kind != 1, kind != 0, 8'($urandom_range(0, 15)), 8'($urandom));
        act[i] = 1;
    endtask

    task automatic drive_random();
        int r;
        bit inflight;
        for (int i = 0; i < N; i++) begin
            inflight = m_busy && (m_idx == i);
            if (m_ack[i]) begin
                act[i] = 0;
                if ($urandom_range(0, 1) == 1) start_req(i);
                else begin
                    rden[i] = 1'b0;
                    wren[i] = 1'b0;
                end
            end else if (!act[i] && !inflight) begin
                if ($urandom_range(0, 3) == 0) start_req(i);
            end else if (act[i] && inflight) begin
                r = $urandom_range(0, 5);
                if (r == 0) begin
                    rden[i] = 1'b0;
                    wren[i] = 1'b0;
                    act[i]  = 0;
                end else if (r < 3) begin
                    Address[i*AW +: AW] = 8'($urandom);
                    Din[i*DW +: DW]     = 8'($urandom);
                end
            end
        end
    endtask

    int n;
    int extra;
    int order [$];
    logic [N-1:0] last_acq;

    initial begin
        for (int a = 0; a < 256; a++) m_mem[a] = init_val(a);
        for (int i = 0; i < N; i++) act[i] = 0;

        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Single read of RAM[5] by requester 1
        set_req(1, 1, 0, 8'h05, 8'h00);
        cycle();
        chk("t1_acq", 64'(acq), 64'(3'b010));
        chk("t1_addr", 64'(RAMAddress), 64'h05);
        wait_ack(1, 10, n);
        chk("t1_latency", 64'(n), 64'd2);
        chk("t1_dq", 64'(Dq[15:8]), 64'hA7);
        chk("t1_acq_off", 64'(acq), 64'd0);
        set_req(1, 0, 0, 8'h00, 8'h00);
        cycle();

        // Single write then read-back by requester 0
        set_req(0, 0, 1, 8'h10, 8'h3C);
        cycle();
        chk("t2_wren", 64'(RAMwren), 64'd1);
        chk("t2_addr", 64'(RAMAddress), 64'h10);
        chk("t2_din", 64'(RAMDin), 64'h3C);
        wait_ack(0, 10, n);
        chk("t2_latency", 64'(n), 64'd1);
        chk("t2_wren_off", 64'(RAMwren), 64'd0);
        set_req(0, 1, 0, 8'h10, 8'h00);
        cycle();
        wait_ack(0, 10, n);
        chk("t2_readback", 64'(Dq[7:0]), 64'h3C);
        set_req(0, 0, 0, 8'h00, 8'h00);
        cycle();

        // rden and wren together: behaves as a write, Dq0 untouched
        set_req(0, 1, 1, 8'h20, 8'h55);
        cycle();
        chk("t5_wren", 64'(RAMwren), 64'd1);
        wait_ack(0, 10, n);
        chk("t5_latency", 64'(n), 64'd1);
        chk("t5_dq_hold", 64'(Dq[7:0]), 64'h3C);
        set_req(0, 0, 0, 8'h00, 8'h00);
        cycle();

        // Requester 2 reads 0x20, holds request through the ack cycle, then drops
        set_req(2, 1, 0, 8'h20, 8'h00);
        cycle();
        wait_ack(2, 10, n);
        chk("t4_dq", 64'(Dq[23:16]), 64'h55);
        cycle();
        set_req(2, 0, 0, 8'h00, 8'h00);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (ack[2] || acq != 0) extra++;
        end
        chk("t4_no_regrant", 64'(extra), 64'd0);

        // Fairness: all requesters read continuously from reset
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 8'(i), 8'h00);
        cycle();
        rst = 1'b0;
        last_acq = '0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (acq != 0 && acq != last_acq) begin
                for (int i = 0; i < N; i++) if (acq[i]) order.push_back(i);
            end
            last_acq = acq;
        end
        chk("t3_grants", 64'(order.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < order.size(); k++) chk("t3_order", 64'(order[k]), 64'(k % N));
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 8'h00, 8'h00);
        for (int c = 0; c < 5; c++) cycle();

        // Reset while a write is in ACCESS
        set_req(0, 0, 1, 8'hF0, 8'h99);
        cycle();
        chk("t6_wren_on", 64'(RAMwren), 64'd1);
        rst = 1'b1;
        set_req(0, 0, 0, 8'h00, 8'h00);
        cycle();
        chk("t6_wren_off", 64'(RAMwren), 64'd0);
        chk("t6_ack", 64'(ack), 64'd0);
        chk("t6_acq", 64'(acq), 64'd0);
        rst = 1'b0;
        cycle();
        set_req(1, 1, 0, 8'h01, 8'h00);
        set_req(2, 1, 0, 8'h02, 8'h00);
        cycle();
        chk("t6_ptr0", 64'(acq), 64'(3'b010));
        wait_ack(1, 10, n);
        set_req(1, 0, 0, 8'h00, 8'h00);
        wait_ack(2, 12, n);
        set_req(2, 0, 0, 8'h00, 8'h00);
        cycle();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            drive_random();
            cycle();
        end
        rden = '0;
        wren = '0;
        for (int c = 0; c < 8; c++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
